simd_regfile_lanes: RTL and testbench

Parametrised SIMD register file that succeeds the 16-bit register_file_2. It provides a configurable number of wide registers split into independent lanes, with two read ports and one lane-masked write port. Read outputs are registered, and a same-cycle write is bypassed to the reads. After reset, a sequential clear sweep zeroes every register. It sits between the SIMD decode stage and the lane ALUs.

---
 rtl/simd_rf_pkg.sv | 23 ++
 rtl/simd_regfile_lanes_if.sv | 35 +++
 rtl/simd_rf_lane_merge.sv | 18 +
 rtl/simd_regfile_lanes.sv | 131 +++++++++++++
 tb/tb_simd_regfile_lanes.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/simd_rf_pkg.sv
// rtl/simd_rf_pkg.sv - shared types and sizing helpers for the SIMD register file
package simd_rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // Number of independent lanes in one register word.
    function automatic int lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    // Elaboration-time sizing checks used by the top level.
    function automatic bit lanes_fit(input int data_w, input int lane_w);
        return (lane_w > 0) && ((data_w % lane_w) == 0);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/simd_regfile_lanes_if.sv
// rtl/simd_regfile_lanes_if.sv - read/write port bundle between SIMD decode and the register file
// master: decode side, drives addresses/enables/write data, receives read data, valids and ready.
// slave : register file side.
interface simd_regfile_lanes_if #(
    parameter int DATA_W   = 64,
    parameter int LANE_W   = 16,
    parameter int NUM_REGS = 32
);
    localparam int LANES  = DATA_W / LANE_W;
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [ADDR_W-1:0] rs1_addr;
    logic              rs1_en;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs2_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [LANES-1:0]  wr_mask;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rs1_data;
    logic              rs1_valid;
    logic [DATA_W-1:0] rs2_data;
    logic              rs2_valid;
    logic              ready;

    modport master (
        output rs1_addr, rs1_en, rs2_addr, rs2_en, rd_addr, wr_en, wr_mask, wr_data,
        input  rs1_data, rs1_valid, rs2_data, rs2_valid, ready
    );

    modport slave (
        input  rs1_addr, rs1_en, rs2_addr, rs2_en, rd_addr, wr_en, wr_mask, wr_data,
        output rs1_data, rs1_valid, rs2_data, rs2_valid, ready
    );
endinterface

// File: rtl/simd_rf_lane_merge.sv
// rtl/simd_rf_lane_merge.sv - per-lane select between an old and a new word
// Ports: old_data (word kept where mask=0), new_data (word taken where mask=1),
//        mask (one bit per lane), merged_data (result).
module simd_rf_lane_merge #(
    parameter int DATA_W = 64,
    parameter int LANE_W = 16,
    localparam int LANES = DATA_W / LANE_W
) (
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] new_data,
    input  logic [LANES-1:0]  mask,
    output logic [DATA_W-1:0] merged_data
);
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign merged_data[l*LANE_W +: LANE_W] =
            mask[l] ? new_data[l*LANE_W +: LANE_W] : old_data[l*LANE_W +: LANE_W];
    end
endmodule

// File: rtl/simd_regfile_lanes.sv
// rtl/simd_regfile_lanes.sv - lane-masked SIMD register file, 2 registered reads, 1 write, clear sweep
// Ports: clk, rst_n (sync active-low), rf (slave side of simd_regfile_lanes_if:
//        rs1/rs2 read requests and registered data/valid, masked write, ready).
module simd_regfile_lanes
    import simd_rf_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int LANE_W   = 16,
    parameter int NUM_REGS = 32,
    localparam int LANES   = lanes(DATA_W, LANE_W),
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    simd_regfile_lanes_if.slave  rf
);
    if (!lanes_fit(DATA_W, LANE_W)) begin : g_bad_lane_w
        $error("DATA_W must be a multiple of LANE_W");
    end
    if (!is_pow2(NUM_REGS)) begin : g_bad_num_regs
        $error("NUM_REGS must be a power of two, at least 2");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic              rs1_valid_q, rs1_valid_d;
    logic              rs2_valid_q, rs2_valid_d;

    logic              is_ready;
    logic              wr_live;
    logic [DATA_W-1:0] wr_word, rs1_word, rs2_word;
    logic [LANES-1:0]  rs1_byp_mask, rs2_byp_mask;

    assign is_ready = (state_q == RF_READY);
    // Writes to r0 are dropped here so neither the array nor the bypass sees them.
    assign wr_live  = is_ready && rf.wr_en && (rf.rd_addr != '0);

    // Bypass only the lanes being written this cycle; other lanes come from the
    // pre-write array contents.
    assign rs1_byp_mask = (wr_live && (rf.rd_addr == rf.rs1_addr)) ? rf.wr_mask : '0;
    assign rs2_byp_mask = (wr_live && (rf.rd_addr == rf.rs2_addr)) ? rf.wr_mask : '0;

    simd_rf_lane_merge #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_wr_merge (
        .old_data    (regs_q[rf.rd_addr]),
        .new_data    (rf.wr_data),
        .mask        (rf.wr_mask),
        .merged_data (wr_word)
    );

    simd_rf_lane_merge #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_rs1_merge (
        .old_data    (regs_q[rf.rs1_addr]),
        .new_data    (rf.wr_data),
        .mask        (rs1_byp_mask),
        .merged_data (rs1_word)
    );

    simd_rf_lane_merge #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_rs2_merge (
        .old_data    (regs_q[rf.rs2_addr]),
        .new_data    (rf.wr_data),
        .mask        (rs2_byp_mask),
        .merged_data (rs2_word)
    );

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        regs_d      = regs_q;
        rs1_data_d  = '0;
        rs1_valid_d = 1'b0;
        rs2_data_d  = '0;
        rs2_valid_d = 1'b0;

        unique case (state_q)
            RF_CLEAR: begin
                regs_d[clr_idx_q] = '0;
                clr_idx_d         = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RF_READY;
                end
            end
            RF_READY: begin
                if (wr_live) begin
                    regs_d[rf.rd_addr] = wr_word;
                end
                if (rf.rs1_en) begin
                    rs1_valid_d = 1'b1;
                    rs1_data_d  = (rf.rs1_addr == '0) ? '0 : rs1_word;
                end
                if (rf.rs2_en) begin
                    rs2_valid_d = 1'b1;
                    rs2_data_d  = (rf.rs2_addr == '0) ? '0 : rs2_word;
                end
            end
            default: state_d = RF_CLEAR;
        endcase

        // r0 is never stored; keep its slot constant.
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        if (!rst_n) begin
            state_q     <= RF_CLEAR;
            clr_idx_q   <= ADDR_W'(1);
            rs1_data_q  <= '0;
            rs1_valid_q <= 1'b0;
            rs2_data_q  <= '0;
            rs2_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rs1_data_q  <= rs1_data_d;
            rs1_valid_q <= rs1_valid_d;
            rs2_data_q  <= rs2_data_d;
            rs2_valid_q <= rs2_valid_d;
        end
    end

    assign rf.rs1_data  = rs1_data_q;
    assign rf.rs1_valid = rs1_valid_q;
    assign rf.rs2_data  = rs2_data_q;
    assign rf.rs2_valid = rs2_valid_q;
    assign rf.ready     = is_ready;
endmodule

// File: tb/tb_simd_regfile_lanes.sv
// tb/tb_simd_regfile_lanes.sv - scoreboard bench for simd_regfile_lanes
module tb_simd_regfile_lanes;
    localparam int DW = 64;
    localparam int LW = 16;
    localparam int NR = 32;
    localparam int NL = DW / LW;
    localparam int AW = $clog2(NR);

    typedef struct {
        logic [DW-1:0] d1;
        logic          v1;
        logic [DW-1:0] d2;
        logic          v2;
        logic          rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simd_regfile_lanes_if #(.DATA_W(DW), .LANE_W(LW), .NUM_REGS(NR)) rf_if ();

    simd_regfile_lanes #(.DATA_W(DW), .LANE_W(LW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_if.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    exp_t sb_q[$];

    logic [DW-1:0] model [NR];
    logic          m_ready = 1'b0;
    int            m_cnt = 1;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [NL-1:0] m);
        logic [DW-1:0] r;
        r = o;
        for (int l = 0; l < NL; l++) if (m[l]) r[l*LW +: LW] = n[l*LW +: LW];
        return r;
    endfunction

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        logic [NL-1:0] bm;
        if (a == '0) return '0;
        bm = (rf_if.wr_en && rf_if.rd_addr == a) ? rf_if.wr_mask : '0;
        return merge(model[a], rf_if.wr_data, bm);
    endfunction

    // One clock: predict from current inputs, push, clock, pop and compare.
    task automatic step();
        exp_t e;
        e.d1 = '0; e.v1 = 1'b0; e.d2 = '0; e.v2 = 1'b0;
        if (!rst_n) begin
            m_ready = 1'b0;
            m_cnt   = 1;
        end else if (!m_ready) begin
            model[m_cnt] = '0;
            if (m_cnt == NR - 1) m_ready = 1'b1;
            m_cnt++;
        end else begin
            if (rf_if.rs1_en) begin e.v1 = 1'b1; e.d1 = rd_model(rf_if.rs1_addr); end
            if (rf_if.rs2_en) begin e.v2 = 1'b1; e.d2 = rd_model(rf_if.rs2_addr); end
            if (rf_if.wr_en && rf_if.rd_addr != '0)
                model[rf_if.rd_addr] = merge(model[rf_if.rd_addr], rf_if.wr_data, rf_if.wr_mask);
        end
        e.rdy = m_ready;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("rs1_data", rf_if.rs1_data, e.d1);
        check("rs1_valid", DW'(rf_if.rs1_valid), DW'(e.v1));
        check("rs2_data", rf_if.rs2_data, e.d2);
        check("rs2_valid", DW'(rf_if.rs2_valid), DW'(e.v2));
        check("ready", DW'(rf_if.ready), DW'(e.rdy));
    endtask

    task automatic idle();
        rf_if.rs1_en = 1'b0; rf_if.rs2_en = 1'b0; rf_if.wr_en = 1'b0;
        rf_if.wr_mask = '0;  rf_if.wr_data = '0;
        rf_if.rs1_addr = '0; rf_if.rs2_addr = '0; rf_if.rd_addr = '0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [NL-1:0] m);
        idle();
        rf_if.wr_en = 1'b1; rf_if.rd_addr = AW'(a); rf_if.wr_data = d; rf_if.wr_mask = m;
        step();
    endtask

    task automatic rd1(input int a);
        idle();
        rf_if.rs1_en = 1'b1; rf_if.rs1_addr = AW'(a);
        step();
    endtask

    int zero_cnt;

    initial begin
        for (int i = 0; i < NR; i++) model[i] = '0;
        idle();

        // Reset and ready polling, with reads issued during the sweep.
        rst_n = 1'b0;
        step();
        check("reset_rs1_data", rf_if.rs1_data, '0);
        check("reset_ready", DW'(rf_if.ready), '0);
        rst_n = 1'b1;
        rf_if.rs1_en = 1'b1; rf_if.rs2_en = 1'b1;
        rf_if.rs1_addr = AW'(5); rf_if.rs2_addr = AW'(9);
        zero_cnt = 0;
        while (!rf_if.ready && zero_cnt < 100) begin
            zero_cnt++;
            step();
        end
        check("ready_low_cycles", DW'(zero_cnt), DW'(31));
        rd1(5);
        check("r5_after_clear", rf_if.rs1_data, '0);

        // Masked write merge.
        wr(3, 64'h1111_2222_3333_4444, 4'hF);
        wr(3, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0101);
        rd1(3);
        check("r3_merge", rf_if.rs1_data, 64'h1111_BBBB_3333_DDDD);
        check("r3_valid", DW'(rf_if.rs1_valid), DW'(1));

        // Same-cycle bypass to both ports.
        idle();
        rf_if.wr_en = 1'b1; rf_if.rd_addr = AW'(7);
        rf_if.wr_data = 64'hDEAD_BEEF_0000_0001; rf_if.wr_mask = 4'b1000;
        rf_if.rs1_en = 1'b1; rf_if.rs2_en = 1'b1;
        rf_if.rs1_addr = AW'(7); rf_if.rs2_addr = AW'(7);
        step();
        check("byp_rs1", rf_if.rs1_data, 64'hDEAD_0000_0000_0000);
        check("byp_rs2", rf_if.rs2_data, 64'hDEAD_0000_0000_0000);

        // r0 stays zero, including bypass.
        wr(0, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF);
        idle();
        rf_if.wr_en = 1'b1; rf_if.rd_addr = '0;
        rf_if.wr_data = 64'hFFFF_FFFF_FFFF_FFFF; rf_if.wr_mask = 4'hF;
        rf_if.rs1_en = 1'b1; rf_if.rs2_en = 1'b1;
        step();
        check("r0_byp_rs1", rf_if.rs1_data, '0);
        check("r0_byp_rs2", rf_if.rs2_data, '0);

        // Mask=0 write is a no-op.
        wr(3, 64'h0, 4'h0);
        rd1(3);
        check("mask0_noop", rf_if.rs1_data, 64'h1111_BBBB_3333_DDDD);

        // Read gap: valid 1,0,1 with zero data in the gap.
        rd1(3);
        check("gap_v0", DW'(rf_if.rs1_valid), DW'(1));
        idle();
        step();
        check("gap_v1", DW'(rf_if.rs1_valid), DW'(0));
        check("gap_d1", rf_if.rs1_data, '0);
        rd1(3);
        check("gap_v2", DW'(rf_if.rs1_valid), DW'(1));

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            rf_if.wr_en    = 1'($urandom_range(0, 1));
            rf_if.rd_addr  = AW'($urandom_range(0, NR - 1));
            rf_if.wr_mask  = NL'($urandom);
            rf_if.wr_data  = {$urandom, $urandom};
            rf_if.rs1_en   = 1'($urandom_range(0, 1));
            rf_if.rs2_en   = 1'($urandom_range(0, 1));
            rf_if.rs1_addr = ($urandom_range(0, 3) == 0) ? rf_if.rd_addr : AW'($urandom_range(0, NR - 1));
            rf_if.rs2_addr = ($urandom_range(0, 3) == 0) ? rf_if.rd_addr : AW'($urandom_range(0, NR - 1));
            step();
        end

        // Fill, then reset mid-traffic.
        for (int a = 1; a < NR; a++) wr(a, {32'hC0DE_0000 | 32'(a), 32'h5A5A_0000 | 32'(a)}, 4'hF);
        idle();
        rf_if.rs1_en = 1'b1; rf_if.rs1_addr = AW'(4);
        rf_if.wr_en = 1'b1; rf_if.rd_addr = AW'(6); rf_if.wr_mask = 4'hF; rf_if.wr_data = 64'h1;
        rst_n = 1'b0;
        step();
        check("midrst_valid", DW'(rf_if.rs1_valid), DW'(0));
        check("midrst_ready", DW'(rf_if.ready), DW'(0));
        rst_n = 1'b1;
        idle();
        zero_cnt = 0;
        while (!rf_if.ready && zero_cnt < 100) begin
            zero_cnt++;
            step();
        end
        check("midrst_low_cycles", DW'(zero_cnt), DW'(31));
        for (int a = 0; a < NR; a++) begin
            idle();
            rf_if.rs1_en = 1'b1; rf_if.rs1_addr = AW'(a);
            rf_if.rs2_en = 1'b1; rf_if.rs2_addr = AW'(NR - 1 - a);
            step();
            check("cleared_rs1", rf_if.rs1_data, '0);
            check("cleared_rs2", rf_if.rs2_data, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
